mem_stage: RTL

- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result (address or data), destination register and store data.
- Performs loads and stores over a valid/ready data-memory port, with byte-lane steering and sign/zero extension.
- Presents a registered result to write-back through a valid/ready handshake, and stalls execute while an access is outstanding.

---
 rtl/mem_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: sits behind execute, performs loads/stores over a
// valid/ready data-memory port with byte-lane steering and load extension,
// and hands a registered result to write-back through valid/ready.
module mem_stage #(
   parameter  int DATA_WIDTH    = 32,
   parameter  int NUM_REGISTERS = 32,
   localparam int ADDRESS_WIDTH = $clog2(NUM_REGISTERS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    in_res,
   input  logic [ADDRESS_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0]    in_store_data,
   input  logic                     in_is_load,
   input  logic                     in_is_store,
   input  logic [2:0]               in_funct3,
   output logic                     dmem_req_valid,
   input  logic                     dmem_req_ready,
   output logic [DATA_WIDTH-1:0]    dmem_req_addr,
   output logic                     dmem_req_we,
   output logic [3:0]               dmem_req_be,
   output logic [DATA_WIDTH-1:0]    dmem_req_wdata,
   input  logic                     dmem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]    dmem_rsp_rdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDRESS_WIDTH-1:0] out_rd,
   output logic [DATA_WIDTH-1:0]    out_res,
   output logic                     out_misaligned
);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   state_t                   state_q;
   logic [ADDRESS_WIDTH-1:0] pend_rd_q;
   logic [DATA_WIDTH-1:0]    pend_res_q;
   logic [2:0]               f3_q;
   logic [1:0]               lo_q;
   logic                     out_valid_q, out_mis_q;
   logic [ADDRESS_WIDTH-1:0] out_rd_q;
   logic [DATA_WIDTH-1:0]    out_res_q;
   logic                     req_valid_q, req_we_q;
   logic [3:0]               req_be_q;
   logic [DATA_WIDTH-1:0]    req_addr_q, req_wdata_q;

   logic                  accept, is_mem, is_st, sz_byte, sz_half, misal;
   logic [3:0]            st_be;
   logic [DATA_WIDTH-1:0] st_wdata, ld_ext;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;

   // Only IDLE takes new work, and only when the output slot frees up this cycle.
   assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Access size from funct3[1:0]; anything not byte/half behaves as a word.
   assign is_mem  = in_is_load || in_is_store;
   assign is_st   = in_is_store && !in_is_load;
   assign sz_byte = (in_funct3[1:0] == 2'b00);
   assign sz_half = (in_funct3[1:0] == 2'b01);
   assign misal   = sz_half ? in_res[0] : (!sz_byte && (in_res[1:0] != 2'b00));

   // Store lane steering: replicate the datum so every enabled lane sees it.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = in_store_data;
      if (sz_byte) begin
         st_be    = 4'b0001 << in_res[1:0];
         st_wdata = {4{in_store_data[7:0]}};
      end else if (sz_half) begin
         st_be    = 4'b0011 << in_res[1:0];
         st_wdata = {2{in_store_data[15:0]}};
      end
   end

   // Load lane selection and sign/zero extension from the captured funct3/offset.
   always_comb begin
      ld_byte = 8'(dmem_rsp_rdata >> {lo_q, 3'b000});
      ld_half = 16'(dmem_rsp_rdata >> {lo_q[1], 4'b0000});
      case (f3_q)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'd0, ld_byte};
         3'b101:  ld_ext = {16'd0, ld_half};
         default: ld_ext = dmem_rsp_rdata;
      endcase
   end

   // Access FSM; memory request and write-back result are both registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pend_rd_q   <= '0;
         pend_res_q  <= '0;
         f3_q        <= '0;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
         out_mis_q   <= 1'b0;
         out_rd_q    <= '0;
         out_res_q   <= '0;
         req_valid_q <= 1'b0;
         req_we_q    <= 1'b0;
         req_be_q    <= '0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
      end else begin
         if (out_valid_q && out_ready) out_valid_q <= 1'b0;
         case (state_q)
            IDLE: if (accept) begin
               if (!is_mem || misal) begin
                  // Pass-through (or faulting access): result ready next cycle.
                  out_valid_q <= 1'b1;
                  out_res_q   <= in_res;
                  out_rd_q    <= in_rd;
                  out_mis_q   <= is_mem && misal;
               end else begin
                  pend_rd_q   <= in_rd;
                  pend_res_q  <= in_res;
                  f3_q        <= in_funct3;
                  lo_q        <= in_res[1:0];
                  req_valid_q <= 1'b1;
                  req_we_q    <= is_st;
                  req_be_q    <= is_st ? st_be : 4'b0000;
                  req_wdata_q <= is_st ? st_wdata : '0;
                  req_addr_q  <= {in_res[DATA_WIDTH-1:2], 2'b00};
                  state_q     <= REQ;
               end
            end
            REQ: if (dmem_req_ready) begin
               req_valid_q <= 1'b0;
               if (req_we_q) begin
                  out_valid_q <= 1'b1;
                  out_res_q   <= pend_res_q;
                  out_rd_q    <= pend_rd_q;
                  out_mis_q   <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  state_q     <= RSP;
               end
            end
            RSP: if (dmem_rsp_valid) begin
               out_valid_q <= 1'b1;
               out_res_q   <= ld_ext;
               out_rd_q    <= pend_rd_q;
               out_mis_q   <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dmem_req_valid = req_valid_q;
   assign dmem_req_addr  = req_addr_q;
   assign dmem_req_we    = req_we_q;
   assign dmem_req_be    = req_be_q;
   assign dmem_req_wdata = req_wdata_q;
   assign out_valid      = out_valid_q;
   assign out_rd         = out_rd_q;
   assign out_res        = out_res_q;
   assign out_misaligned = out_mis_q;

endmodule
